// File: rtl/proc_pkg.sv
// ============================================================================
// proc_pkg : shared types and constants for the processor program loader
// Revision : 1.0
// ============================================================================
`default_nettype none

package proc_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR1 = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } loader_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   localparam int DEF_CLKS_PER_BIT = 434;
   localparam int IMEM_ADDR_W      = 12;

endpackage

`default_nettype wire

// File: rtl/m_uart_rx.sv
// ============================================================================
// m_uart_rx : 8N1 UART receiver with 2-flop synchronizer and false-start reject
// Revision  : 1.0
// ============================================================================
`default_nettype none

module m_uart_rx
   import proc_pkg::*;
#(
   parameter int P_CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       w_clk,
   input  logic       w_rst_n,
   input  logic       w_rxd,
   output logic       w_bvalid,
   output logic [7:0] w_byte,
   output logic       w_ferr
);

   localparam int CNT_W = $clog2(P_CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(P_CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] C_HALF = CNT_W'(P_CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   rx_state_t        rx_state;
   logic             rxd_s1;
   logic             rxd_s2;
   logic             rxd_d;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         rxd_s1   <= 1'b1;
         rxd_s2   <= 1'b1;
         rxd_d    <= 1'b1;
         rx_state <= RX_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         w_bvalid <= 1'b0;
         w_byte   <= '0;
         w_ferr   <= 1'b0;
      end else begin
         rxd_s1   <= w_rxd;
         rxd_s2   <= rxd_s1;
         rxd_d    <= rxd_s2;
         w_bvalid <= 1'b0;
         w_ferr   <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rxd_d && !rxd_s2) begin
                  rx_state <= RX_START;
                  cnt      <= '0;
               end
            end
            RX_START: begin
               // Line back high at mid start bit means a glitch, not a frame.
               if (cnt == C_HALF) begin
                  cnt      <= '0;
                  bit_idx  <= '0;
                  rx_state <= rxd_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + C_ONE;
               end
            end
            RX_DATA: begin
               if (cnt == C_FULL) begin
                  cnt     <= '0;
                  shreg   <= {rxd_s2, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     rx_state <= RX_STOP;
                  end
               end else begin
                  cnt <= cnt + C_ONE;
               end
            end
            RX_STOP: begin
               if (cnt == C_FULL) begin
                  cnt      <= '0;
                  rx_state <= RX_IDLE;
                  if (rxd_s2) begin
                     w_bvalid <= 1'b1;
                     w_byte   <= shreg;
                  end else begin
                     w_ferr <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + C_ONE;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/m_imem_loader.sv
// ============================================================================
// m_imem_loader : UART program loader driving the instruction-memory write port
// Option        : LOADER_CHECKSUM_EN adds a trailing mod-256 checksum byte
// Revision      : 1.0
// ============================================================================
`default_nettype none

module m_imem_loader
   import proc_pkg::*;
#(
   parameter int P_CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int P_ADDR_W       = IMEM_ADDR_W
) (
   input  logic                w_clk,
   input  logic                w_rst_n,
   input  logic                w_rxd,
   input  logic                w_run,
   output logic                r_busy,
   output logic                r_done,
   output logic                r_err,
   output logic                r_we,
   output logic [P_ADDR_W-1:0] r_addr,
   output logic [31:0]         r_wdata,
   output logic [P_ADDR_W:0]   r_nwords
);

   localparam int NW_W = P_ADDR_W + 1;
   localparam logic [NW_W-1:0]     C_ONE_W = NW_W'(1);
   localparam logic [P_ADDR_W-1:0] C_ONE_A = P_ADDR_W'(1);
   localparam logic [16:0]         C_MAX_N = 17'(1 << P_ADDR_W);

   logic          bvalid;
   logic [7:0]    rx_byte;
   logic          ferr;

   loader_state_t state;
   logic [7:0]    n_lo;
   logic [NW_W-1:0] n_tgt;
   logic [1:0]    bidx;
   logic [15:0]   hdr_n;
   logic          hdr_bad;
   logic [NW_W-1:0] nwords_nxt;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]    sum;
`endif

   m_uart_rx #(
      .P_CLKS_PER_BIT (P_CLKS_PER_BIT)
   ) u_rx (
      .w_clk    (w_clk),
      .w_rst_n  (w_rst_n),
      .w_rxd    (w_rxd),
      .w_bvalid (bvalid),
      .w_byte   (rx_byte),
      .w_ferr   (ferr)
   );

   assign hdr_n      = {rx_byte, n_lo};
   assign hdr_bad    = (hdr_n == 16'd0) || ({1'b0, hdr_n} > C_MAX_N);
   assign nwords_nxt = r_nwords + C_ONE_W;

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state    <= S_IDLE;
         n_lo     <= '0;
         n_tgt    <= '0;
         bidx     <= '0;
         r_busy   <= 1'b1;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_nwords <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum      <= '0;
`endif
      end else begin
         r_we <= 1'b0;
         // A broken frame poisons the load, but a running program ignores line noise.
         if (ferr && state != S_DONE) begin
            state  <= S_ERR;
            r_err  <= 1'b1;
            r_busy <= 1'b1;
            r_done <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (bvalid) begin
                     n_lo  <= rx_byte;
                     state <= S_HDR1;
`ifdef LOADER_CHECKSUM_EN
                     sum   <= rx_byte;
`endif
                  end else if (w_run) begin
                     state  <= S_DONE;
                     r_busy <= 1'b0;
                     r_done <= 1'b1;
                  end
               end
               S_HDR1: begin
                  if (bvalid) begin
`ifdef LOADER_CHECKSUM_EN
                     sum <= sum + rx_byte;
`endif
                     if (hdr_bad) begin
                        state <= S_ERR;
                        r_err <= 1'b1;
                     end else begin
                        n_tgt <= NW_W'(hdr_n);
                        bidx  <= '0;
                        state <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (r_we) begin
                     r_addr   <= r_addr + C_ONE_A;
                     r_nwords <= nwords_nxt;
                     if (nwords_nxt == n_tgt) begin
`ifdef LOADER_CHECKSUM_EN
                        state  <= S_CSUM;
`else
                        state  <= S_DONE;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
`endif
                     end
                  end else if (bvalid) begin
                     r_wdata <= {rx_byte, r_wdata[31:8]};
                     bidx    <= bidx + 2'd1;
                     r_we    <= (bidx == 2'd3);
`ifdef LOADER_CHECKSUM_EN
                     sum     <= sum + rx_byte;
`endif
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               S_CSUM: begin
                  if (bvalid) begin
                     if (rx_byte == sum) begin
                        state  <= S_DONE;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                     end else begin
                        state <= S_ERR;
                        r_err <= 1'b1;
                     end
                  end
               end
`endif
               S_DONE: begin
                  if (bvalid) begin
                     n_lo     <= rx_byte;
                     r_addr   <= '0;
                     r_nwords <= '0;
                     r_busy   <= 1'b1;
                     r_done   <= 1'b0;
                     state    <= S_HDR1;
`ifdef LOADER_CHECKSUM_EN
                     sum      <= rx_byte;
`endif
                  end
               end
               S_ERR: begin
                  r_busy <= 1'b1;
                  r_err  <= 1'b1;
               end
               default: begin
                  state <= S_ERR;
                  r_err <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_m_imem_loader.sv
// ============================================================================
// tb_m_imem_loader : randomized self-checking bench for the UART program loader
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_m_imem_loader;

   localparam int CPB = 8;
   localparam int AW  = 12;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          rxd   = 1'b1;
   logic          run   = 1'b0;
   logic          r_busy, r_done, r_err, r_we;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [AW:0]   r_nwords;

   int n_cmp = 0;
   int n_bad = 0;

   logic [AW-1:0] wq_addr[$];
   logic [31:0]   wq_data[$];
   logic [31:0]   exp_w[$];
   logic [7:0]    tx_q[$];
   int cyc = 0, last_we_cyc = 0, done_rise_cyc = 0, bv_cnt = 0;
   logic done_q = 1'b0;

   always #5 clk = ~clk;

   m_imem_loader #(
      .P_CLKS_PER_BIT (CPB),
      .P_ADDR_W       (AW)
   ) dut (
      .w_clk    (clk),
      .w_rst_n  (rst_n),
      .w_rxd    (rxd),
      .w_run    (run),
      .r_busy   (r_busy),
      .r_done   (r_done),
      .r_err    (r_err),
      .r_we     (r_we),
      .r_addr   (r_addr),
      .r_wdata  (r_wdata),
      .r_nwords (r_nwords)
   );

   // Write-port and event monitor, sampled mid-cycle.
   always @(negedge clk) begin
      cyc++;
      if (r_we === 1'b1) begin
         wq_addr.push_back(r_addr);
         wq_data.push_back(r_wdata);
         last_we_cyc = cyc;
      end
      if (r_done === 1'b1 && done_q !== 1'b1) done_rise_cyc = cyc;
      done_q = r_done;
      if (dut.bvalid === 1'b1) bv_cnt++;
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk) rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = stop;
      repeat (CPB) @(negedge clk);
      rxd = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_q(input int first, input int last);
      for (int i = first; i <= last; i++) send_byte(tx_q[i], 1'b1);
   endtask

   // Frame model: header N (LE), words LE, optional mod-256 sum of everything.
   task automatic make_frame();
      int s;
      tx_q.delete();
      tx_q.push_back(8'(exp_w.size()));
      tx_q.push_back(8'(exp_w.size() >> 8));
      foreach (exp_w[i]) begin
         for (int k = 0; k < 4; k++) tx_q.push_back(8'(exp_w[i] >> (8 * k)));
      end
`ifdef LOADER_CHECKSUM_EN
      s = 0;
      foreach (tx_q[i]) s += int'(tx_q[i]);
      tx_q.push_back(8'(s));
`else
      s = 0;
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      rxd   = 1'b1;
      run   = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      wq_addr.delete();
      wq_data.delete();
   endtask

   task automatic check_writes(input string tag);
      n_cmp++;
      if (wq_addr.size() != exp_w.size()) begin
         n_bad++;
         $display("FAIL %s_count: got %0d writes, want %0d", tag, wq_addr.size(), exp_w.size());
      end
      for (int i = 0; i < exp_w.size() && i < wq_addr.size(); i++) begin
         n_cmp++;
         if (wq_addr[i] !== AW'(i) || wq_data[i] !== exp_w[i]) begin
            n_bad++;
            $display("FAIL %s_word%0d: got addr %0d data %h, want addr %0d data %h",
                     tag, i, wq_addr[i], wq_data[i], i, exp_w[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({r_busy, r_done, r_err, r_we} !== 4'b1000 || r_addr !== '0 || r_nwords !== '0 || r_wdata !== '0) begin
         n_bad++;
         $display("FAIL reset_vals: got busy%b done%b err%b we%b addr%0d nw%0d wd%h, want 1 0 0 0 0 0 0",
                  r_busy, r_done, r_err, r_we, r_addr, r_nwords, r_wdata);
      end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      n_cmp++;
      if ({r_busy, r_done, r_err, r_we} !== 4'b1000) begin
         n_bad++;
         $display("FAIL reset_idle: got busy%b done%b err%b we%b, want 1 0 0 0", r_busy, r_done, r_err, r_we);
      end
   endtask

   task automatic test_spec_frame();
      do_reset();
      exp_w.delete();
      exp_w.push_back(32'h0000_0020);
      exp_w.push_back(32'h2001_0001);
      make_frame();
      send_q(0, tx_q.size() - 1);
      repeat (20) @(negedge clk);
      check_writes("spec");
      n_cmp++;
      if (r_done !== 1'b1 || r_busy !== 1'b0 || r_err !== 1'b0 || r_nwords !== 13'd2) begin
         n_bad++;
         $display("FAIL spec_status: got done%b busy%b err%b nw%0d, want 1 0 0 2", r_done, r_busy, r_err, r_nwords);
      end
      n_cmp++;
`ifdef LOADER_CHECKSUM_EN
      if (done_rise_cyc <= last_we_cyc) begin
`else
      if (done_rise_cyc != last_we_cyc + 1) begin
`endif
         n_bad++;
         $display("FAIL spec_done_timing: got done at %0d, last we at %0d", done_rise_cyc, last_we_cyc);
      end
   endtask

   // Successive frames from S_DONE exercise the restart path.
   task automatic test_random_frames();
      int n;
      for (int f = 0; f < 3; f++) begin
         n = $urandom_range(1, 4);
         exp_w.delete();
         for (int i = 0; i < n; i++) exp_w.push_back($urandom);
         make_frame();
         wq_addr.delete();
         wq_data.delete();
         send_q(0, 1);
         repeat (2) @(negedge clk);
         n_cmp++;
         if (r_busy !== 1'b1 || r_done !== 1'b0 || r_nwords !== '0) begin
            n_bad++;
            $display("FAIL rand%0d_restart: got busy%b done%b nw%0d, want 1 0 0", f, r_busy, r_done, r_nwords);
         end
         send_q(2, tx_q.size() - 1);
         repeat (20) @(negedge clk);
         check_writes($sformatf("rand%0d", f));
         n_cmp++;
         if (r_done !== 1'b1 || r_busy !== 1'b0 || r_nwords !== (AW + 1)'(n)) begin
            n_bad++;
            $display("FAIL rand%0d_status: got done%b busy%b nw%0d, want 1 0 %0d", f, r_done, r_busy, r_nwords, n);
         end
      end
   endtask

   task automatic test_zero_header();
      do_reset();
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
      repeat (10) @(negedge clk);
      n_cmp++;
      if (r_err !== 1'b1 || r_busy !== 1'b1 || r_done !== 1'b0 || wq_addr.size() != 0) begin
         n_bad++;
         $display("FAIL zero_hdr: got err%b busy%b done%b writes%0d, want 1 1 0 0", r_err, r_busy, r_done, wq_addr.size());
      end
   endtask

   task automatic test_hdr_bounds();
      do_reset();
      send_byte(8'h01, 1'b1);
      send_byte(8'h10, 1'b1);
      repeat (5) @(negedge clk);
      n_cmp++;
      if (r_err !== 1'b1) begin
         n_bad++;
         $display("FAIL hdr_4097: got err%b, want 1", r_err);
      end
      do_reset();
      send_byte(8'h00, 1'b1);
      send_byte(8'h10, 1'b1);
      repeat (5) @(negedge clk);
      n_cmp++;
      if (r_err !== 1'b0 || r_busy !== 1'b1 || r_done !== 1'b0) begin
         n_bad++;
         $display("FAIL hdr_4096: got err%b busy%b done%b, want 0 1 0", r_err, r_busy, r_done);
      end
   endtask

`ifdef LOADER_CHECKSUM_EN
   task automatic test_bad_checksum();
      do_reset();
      exp_w.delete();
      exp_w.push_back(32'h0000_0020);
      exp_w.push_back(32'h2001_0001);
      make_frame();
      tx_q[tx_q.size() - 1] = tx_q[tx_q.size() - 1] + 8'd1;
      send_q(0, tx_q.size() - 1);
      repeat (10) @(negedge clk);
      n_cmp++;
      if (r_err !== 1'b1 || r_done !== 1'b0 || r_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL bad_csum: got err%b done%b busy%b, want 1 0 1", r_err, r_done, r_busy);
      end
   endtask
`endif

   task automatic test_ferr();
      do_reset();
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h20, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b0);
      repeat (5) @(negedge clk);
      n_cmp++;
      if (r_err !== 1'b1 || r_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL ferr_err: got err%b busy%b, want 1 1", r_err, r_busy);
      end
      for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b1);
      repeat (5) @(negedge clk);
      n_cmp++;
      if (r_err !== 1'b1 || r_busy !== 1'b1 || wq_addr.size() != 0) begin
         n_bad++;
         $display("FAIL ferr_sticky: got err%b busy%b writes%0d, want 1 1 0", r_err, r_busy, wq_addr.size());
      end
      do_reset();
      n_cmp++;
      if (r_err !== 1'b0) begin
         n_bad++;
         $display("FAIL ferr_clear: got err%b, want 0", r_err);
      end
   endtask

   task automatic test_false_start_run();
      int bv0;
      do_reset();
      bv0 = bv_cnt;
      @(negedge clk) rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      repeat (30) @(negedge clk);
      n_cmp++;
      if (bv_cnt != bv0 || r_busy !== 1'b1 || r_done !== 1'b0 || r_err !== 1'b0) begin
         n_bad++;
         $display("FAIL glitch: got bvalids%0d busy%b done%b err%b, want 0 1 0 0", bv_cnt - bv0, r_busy, r_done, r_err);
      end
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      n_cmp++;
      if (r_done !== 1'b1 || r_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL run_bypass: got done%b busy%b, want 1 0", r_done, r_busy);
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      exp_w.delete();
      exp_w.push_back($urandom);
      exp_w.push_back($urandom);
      make_frame();
      send_q(0, 5);
      repeat (10) @(negedge clk);
      n_cmp++;
      if (r_nwords !== 13'd1 || r_addr !== 12'd1) begin
         n_bad++;
         $display("FAIL mid_pre: got nw%0d addr%0d, want 1 1", r_nwords, r_addr);
      end
      @(negedge clk) rxd = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({r_busy, r_done, r_err, r_we} !== 4'b1000 || r_addr !== '0 || r_nwords !== '0 || r_wdata !== '0) begin
         n_bad++;
         $display("FAIL mid_async: got busy%b done%b err%b we%b addr%0d nw%0d wd%h, want 1 0 0 0 0 0 0",
                  r_busy, r_done, r_err, r_we, r_addr, r_nwords, r_wdata);
      end
      @(negedge clk) rxd = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      wq_addr.delete();
      wq_data.delete();
      exp_w.delete();
      exp_w.push_back($urandom);
      make_frame();
      send_q(0, tx_q.size() - 1);
      repeat (20) @(negedge clk);
      check_writes("post_rst");
      n_cmp++;
      if (r_done !== 1'b1 || r_nwords !== 13'd1) begin
         n_bad++;
         $display("FAIL post_rst_status: got done%b nw%0d, want 1 1", r_done, r_nwords);
      end
   endtask

   initial begin
      test_reset();
      test_spec_frame();
      test_random_frames();
      test_zero_header();
      test_hdr_bounds();
`ifdef LOADER_CHECKSUM_EN
      test_bad_checksum();
`endif
      test_ferr();
      test_false_start_run();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/m_imem_loader.md
# m_imem_loader

Serial program loader that sits directly upstream of the pipelined processor's instruction memory. It receives a framed program over a UART line, assembles 32-bit little-endian words and drives a single-cycle write port into the instruction memory. It holds the processor in reset (`r_busy`) until the load completes or is bypassed. The top level ORs `r_busy` into the processor reset and muxes `r_we`/`r_addr`/`r_wdata` onto the instruction-memory port.

## Interface
- `P_CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- `P_ADDR_W`, default 12: word-address width (4096-word memory).
- `w_clk`  in  1  system clock, all logic on rising edge.
- `w_rst_n`  in  1  reset, asynchronous, active-low.
- `w_rxd`  in  1  UART receive line, idle high, 8N1, LSB first.
- `w_run`  in  1  bypass request; honoured only in `S_IDLE`.
- `r_busy`  out  1  processor hold; reset value 1.
- `r_done`  out  1  load complete; reset value 0.
- `r_err`  out  1  sticky error; reset value 0.
- `r_we`  out  1  one-cycle imem write strobe; reset value 0.
- `r_addr`  out  P_ADDR_W  word address of the current write; reset value 0.
- `r_wdata`  out  32  write data; reset value 0.
- `r_nwords`  out  P_ADDR_W+1  words written so far; reset value 0.

## Operation
- UART RX:
  - `w_rxd` passes through a 2-flop synchronizer (reset value 1).
  - A falling edge starts a bit timer. At half a bit the line is re-sampled; if high, it is a false start and the receiver returns to idle.
  - Otherwise the 8 data bits are sampled at mid-bit, then the stop bit.
  - A stop bit of 1 produces a 1-cycle byte-valid pulse. A stop bit of 0 produces a framing-error pulse.
- Frame format: 2-byte word count N (little-endian), then N×4 data bytes (little-endian words).
  - With `LOADER_CHECKSUM_EN`, a trailing byte follows: the mod-256 sum of all header and data bytes.
- States: `S_IDLE` → `S_HDR1` → `S_DATA` → [`S_CSUM`] → `S_DONE`; `S_ERR`.
  - `S_IDLE`: a byte → latch N[7:0], go to `S_HDR1`. `w_run`=1 with no byte that cycle → `S_DONE`.
  - `S_HDR1`: a byte → latch N[15:8]. If N==0 or N > 2^P_ADDR_W → `S_ERR`, else `S_DATA`.
  - `S_DATA`: a 2-bit byte index shifts bytes into `r_wdata`, byte 0 → bits [7:0]. On the 4th byte, pulse `r_we` with `r_addr` = word index. After the write, increment `r_addr` and `r_nwords`. When `r_nwords` reaches N → `S_CSUM` or `S_DONE`.
  - `S_CSUM`: received byte equals the running sum → `S_DONE`, else `S_ERR`.
  - `S_DONE`: `r_busy`=0, `r_done`=1. A new byte restarts the load: treated as the N low byte, `r_addr`/`r_nwords` cleared, `r_busy`=1, `r_done`=0, go to `S_HDR1`.
  - `S_ERR`: `r_busy`=1, `r_err`=1, no writes. Left only by reset.
- A framing error in any state except `S_DONE` → `S_ERR`. In `S_DONE` it is ignored.
- Address wrap: not possible, because N is bounded by 2^P_ADDR_W.

## Timing
- Byte-valid pulses 1 cycle after the stop-bit sample.
- `r_we` asserts on the cycle after the 4th byte-valid. `r_addr` and `r_wdata` are stable during `r_we`. `r_addr` increments on the following edge.
- `r_done`/`r_busy` change on the cycle after the final `r_we` (or after the checksum byte-valid).
- `w_run` → `r_busy`=0 on the next edge.
- A byte-valid and `w_run` in the same cycle in `S_IDLE`: the byte wins.
- Asynchronous reset at any point, including mid-byte or mid-frame: all outputs take their reset values immediately, and the RX goes to idle. The next frame loads from address 0.
- All outputs are registered; there is no combinational path from `w_rxd`.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The running 8-bit sum register and `S_CSUM` are present.
  - A mismatch sets `r_err`; no `r_done` until the checksum matches.
- Not defined: no sum logic. `S_DATA` goes straight to `S_DONE` after the N-th write.

## Structure
- Shared package `proc_pkg`:
  - State enum `loader_state_t`.
  - Constant `DEF_CLKS_PER_BIT` = 434.
  - Constant `IMEM_ADDR_W` = 12.
- One sub-module, `m_uart_rx`:
  - Synchronizer, bit timer and shift register.
  - Outputs `w_bvalid`, `w_byte[7:0]`, `w_ferr`.
- The frame FSM, byte assembly and counters live in `m_imem_loader`.

## Test plan
All scenarios use P_CLKS_PER_BIT=8.
- Reset → `r_busy`=1, `r_done`=0, `r_err`=0, `r_we`=0, `r_addr`=0, `r_nwords`=0.
- Send 02 00 | 20 00 00 00 | 01 00 01 20 (+ 44 with checksum) → `r_we` at addr 0 with 0x00000020, then at addr 1 with 0x20010001. Then `r_done`=1, `r_busy`=0, `r_nwords`=2.
- Header 00 00 → `r_err`=1, `r_busy`=1, no `r_we`. Checksum build, trailing byte 45 instead of 44 → `r_err`=1.
- Stop bit forced low on the 3rd data byte → `r_err`=1, no further `r_we`, stays in error until `w_rst_n` pulse.
- `w_rxd` low for 3 cycles (< half bit) → no byte-valid, state unchanged. `w_run`=1 in `S_IDLE` → `r_done`=1, `r_busy`=0 next cycle.
- `w_rst_n` low during the 5th data byte → outputs reset at once. A subsequent 1-word frame writes addr 0.
